// File: rtl/demux2_rr.sv
// demux2_rr: 1-to-2 round-robin lane splitter.
// Successive accepted input words go strictly alternately to lane 0 and lane 1.
// Each lane is a 1-entry registered buffer with its own valid/ready handshake.
module demux2_rr #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i,
   input  logic             i_valid,
   output logic             i_ready,
   output logic [WIDTH-1:0] q0,
   output logic             q0_valid,
   input  logic             q0_ready,
   output logic [WIDTH-1:0] q1,
   output logic             q1_valid,
   input  logic             q1_ready,
   output logic             nxt
);

   // Lane selector encodings (nxt is the round-robin pointer)
   localparam logic [0:0] LANE0 = 1'b0;
   localparam logic [0:0] LANE1 = 1'b1;

   logic             tgt_valid;
   logic             tgt_ready;
   logic             load;
   logic             load0;
   logic             load1;
   logic             nxt_d;
   logic             q0_valid_d;
   logic             q1_valid_d;
   logic [WIDTH-1:0] q0_d;
   logic [WIDTH-1:0] q1_d;

   // Next-state and input handshake; alternation is never skipped, so only
   // the target lane's occupancy decides i_ready.
   always_comb begin
      tgt_valid  = q0_valid;
      tgt_ready  = q0_ready;
      i_ready    = 1'b0;
      load       = 1'b0;
      load0      = 1'b0;
      load1      = 1'b0;
      nxt_d      = nxt;
      q0_valid_d = q0_valid;
      q1_valid_d = q1_valid;
      q0_d       = q0;
      q1_d       = q1;

      if (nxt == LANE1) begin
         tgt_valid = q1_valid;
         tgt_ready = q1_ready;
      end

      i_ready = ~tgt_valid | tgt_ready;
      load    = i_valid & i_ready;
      load0   = load & (nxt == LANE0);
      load1   = load & (nxt == LANE1);

      if (load) begin
         nxt_d = ~nxt;
      end

      // Drain clears valid; a load on the same edge wins and keeps it set.
      if (q0_valid & q0_ready) begin
         q0_valid_d = 1'b0;
      end
      if (load0) begin
         q0_valid_d = 1'b1;
         q0_d       = i;
      end

      if (q1_valid & q1_ready) begin
         q1_valid_d = 1'b0;
      end
      if (load1) begin
         q1_valid_d = 1'b1;
         q1_d       = i;
      end
   end

   // State registers; reset discards any held words and returns to lane 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nxt      <= LANE0;
         q0_valid <= 1'b0;
         q1_valid <= 1'b0;
         q0       <= '0;
         q1       <= '0;
      end else begin
         nxt      <= nxt_d;
         q0_valid <= q0_valid_d;
         q1_valid <= q1_valid_d;
         q0       <= q0_d;
         q1       <= q1_d;
      end
   end

endmodule

// File: tb/tb_demux2_rr.sv
// Self-checking bench for demux2_rr: directed steps plus a random stress phase,
// with a per-lane scoreboard fed from an independent occupancy model.
module tb_demux2_rr;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] i;
   logic             i_valid;
   logic             i_ready;
   logic [WIDTH-1:0] q0;
   logic             q0_valid;
   logic             q0_ready;
   logic [WIDTH-1:0] q1;
   logic             q1_valid;
   logic             q1_ready;
   logic             nxt;

   int total = 0;
   int bad   = 0;

   // Scoreboard: words expected on each lane, front = word currently held
   logic [WIDTH-1:0] exp0[$];
   logic [WIDTH-1:0] exp1[$];
   logic             mnxt;
   logic             er;
   logic             acc;

   demux2_rr #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .i        (i),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .q0       (q0),
      .q0_valid (q0_valid),
      .q0_ready (q0_ready),
      .q1       (q1),
      .q1_valid (q1_valid),
      .q1_ready (q1_ready),
      .nxt      (nxt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model check on the falling edge: occupancy, pointer, ready, lane data,
   // then retire drained words and queue the newly accepted word.
   always @(negedge clk) begin
      if (rst) begin
         exp0.delete();
         exp1.delete();
         mnxt = 1'b0;
      end else begin
         er = mnxt ? (exp1.size() == 0 || q1_ready) : (exp0.size() == 0 || q0_ready);
         chk("i_ready", 64'(i_ready), 64'(er));
         chk("nxt", 64'(nxt), 64'(mnxt));
         chk("q0_valid", 64'(q0_valid), 64'(exp0.size() != 0));
         chk("q1_valid", 64'(q1_valid), 64'(exp1.size() != 0));
         if (exp0.size() != 0) begin
            chk("q0_data", 64'(q0), 64'(exp0[0]));
            if (q0_ready) void'(exp0.pop_front());
         end
         if (exp1.size() != 0) begin
            chk("q1_data", 64'(q1), 64'(exp1[0]));
            if (q1_ready) void'(exp1.pop_front());
         end
         if (i_valid && er) begin
            if (mnxt) exp1.push_back(i);
            else      exp0.push_back(i);
            mnxt = ~mnxt;
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] w[4];
      w = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      rst = 1'b0; i = '0; i_valid = 1'b0; q0_ready = 1'b0; q1_ready = 1'b0;
      acc = 1'b0; mnxt = 1'b0;

      // Reset state, before any clock edge
      #1 rst = 1'b1;
      #2;
      chk("rst_q0", 64'(q0), 64'h0);
      chk("rst_q1", 64'(q1), 64'h0);
      chk("rst_q0_valid", 64'(q0_valid), 64'h0);
      chk("rst_q1_valid", 64'(q1_valid), 64'h0);
      chk("rst_nxt", 64'(nxt), 64'h0);
      chk("rst_i_ready", 64'(i_ready), 64'h1);
      tick();
      tick();
      rst = 1'b0;

      // 1: free-running stream, alternating lanes
      q0_ready = 1'b1; q1_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         i = w[k]; i_valid = 1'b1;
         #1;
         chk("t1_i_ready", 64'(i_ready), 64'h1);
         chk("t1_nxt", 64'(nxt), 64'(k % 2));
         tick();
         if (k % 2 == 0) chk("t1_q0", 64'(q0), 64'(w[k]));
         else            chk("t1_q1", 64'(q1), 64'(w[k]));
      end
      i_valid = 1'b0;
      chk("t1_nxt_end", 64'(nxt), 64'h0);

      // 2: lane 0 stalled blocks input destined for it; load wins over drain
      q0_ready = 1'b0;
      i = 8'h11; i_valid = 1'b1; tick();
      i = 8'h22; tick();
      i = 8'h33; #1;
      chk("t2_i_ready_blk", 64'(i_ready), 64'h0);
      chk("t2_q0_hold", 64'(q0), 64'h11);
      chk("t2_q1", 64'(q1), 64'h22);
      tick();
      chk("t2_i_ready_blk2", 64'(i_ready), 64'h0);
      chk("t2_q0_hold2", 64'(q0), 64'h11);
      q0_ready = 1'b1; #1;
      chk("t2_i_ready_rel", 64'(i_ready), 64'h1);
      tick();
      chk("t2_q0_load", 64'(q0), 64'h33);
      chk("t2_q0_valid", 64'(q0_valid), 64'h1);
      i_valid = 1'b0; tick();
      chk("t2_q0_drained", 64'(q0_valid), 64'h0);

      // 3: lane 1 stalled, lane 0 empty, pointer on lane 1 -> no skip
      q1_ready = 1'b0;
      i = 8'h44; i_valid = 1'b1; tick();
      i = 8'h55; tick();
      i = 8'h66; tick();
      chk("t3_i_ready", 64'(i_ready), 64'h0);
      chk("t3_q0_valid", 64'(q0_valid), 64'h0);
      chk("t3_q1_valid", 64'(q1_valid), 64'h1);
      chk("t3_q1", 64'(q1), 64'h44);
      chk("t3_nxt", 64'(nxt), 64'h1);
      tick();
      chk("t3_q0_still_empty", 64'(q0_valid), 64'h0);
      q1_ready = 1'b1; tick();
      chk("t3_q1_load", 64'(q1), 64'h66);
      chk("t3_nxt_after", 64'(nxt), 64'h0);
      i_valid = 1'b0; tick();

      // 4: both lanes drain on one edge, data retained
      q0_ready = 1'b0; q1_ready = 1'b0;
      i = 8'h77; i_valid = 1'b1; tick();
      i = 8'h88; tick();
      i_valid = 1'b0; #1;
      chk("t4_q0_full", 64'(q0_valid), 64'h1);
      chk("t4_q1_full", 64'(q1_valid), 64'h1);
      q0_ready = 1'b1; q1_ready = 1'b1; tick();
      chk("t4_q0_valid", 64'(q0_valid), 64'h0);
      chk("t4_q1_valid", 64'(q1_valid), 64'h0);
      chk("t4_q0_keep", 64'(q0), 64'h77);
      chk("t4_q1_keep", 64'(q1), 64'h88);

      // 5: asynchronous reset mid-stream with both lanes full, pointer on 1
      q0_ready = 1'b1; q1_ready = 1'b0;
      i = 8'h99; i_valid = 1'b1; tick();
      i = 8'hAA; tick();
      i = 8'hBB; tick();
      i_valid = 1'b0; q0_ready = 1'b0; #1;
      chk("t5_pre_q0v", 64'(q0_valid), 64'h1);
      chk("t5_pre_q1v", 64'(q1_valid), 64'h1);
      chk("t5_pre_nxt", 64'(nxt), 64'h1);
      rst = 1'b1; #1;
      chk("t5_q0_valid", 64'(q0_valid), 64'h0);
      chk("t5_q1_valid", 64'(q1_valid), 64'h0);
      chk("t5_q0", 64'(q0), 64'h0);
      chk("t5_q1", 64'(q1), 64'h0);
      chk("t5_nxt", 64'(nxt), 64'h0);
      tick();
      rst = 1'b0;
      q0_ready = 1'b1; q1_ready = 1'b1;
      i = 8'hCC; i_valid = 1'b1; #1;
      chk("t5_first_nxt", 64'(nxt), 64'h0);
      tick();
      chk("t5_first_q0", 64'(q0), 64'hCC);
      chk("t5_first_q0v", 64'(q0_valid), 64'h1);
      i_valid = 1'b0; tick();

      // 6: random valid/ready stress; producer holds word until accepted
      acc = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         q0_ready = ($urandom_range(0, 3) != 0);
         q1_ready = ($urandom_range(0, 3) != 0);
         if (!i_valid || acc) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i = WIDTH'($urandom);
         end
         #3;
         acc = i_valid & i_ready;
         tick();
      end
      i_valid = 1'b0; q0_ready = 1'b1; q1_ready = 1'b1;
      tick(); tick(); tick();
      chk("t6_lane0_drained", 64'(exp0.size()), 64'h0);
      chk("t6_lane1_drained", 64'(exp1.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
